window_burst_reader: RTL and testbench

AXI4 read initiator that drains captured windows from ThresholdCutter's window RAM. Watches the per-window flag vector and latches each rising flag as a pending window. Issues one INCR burst per pending window on ThresholdCutter's AXI read slave port. Streams the returned beats downstream, tagged with the window index, toward the PS/feature pipeline.

---
 rtl/window_burst_reader_pkg.sv | 23 ++
 rtl/window_burst_reader_if.sv | 39 +++
 rtl/window_burst_reader_pending_scanner.sv | 56 +++++
 rtl/window_burst_reader.sv | 126 ++++++++++++
 tb/tb_window_burst_reader.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/window_burst_reader_pkg.sv
// Shared AXI constants, read-FSM state type and window address helper
// for the ThresholdCutter window-drain path.
package threshold_cutter_pkg;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_32B   = 3'd5;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam int unsigned BEAT_BYTES_LOG2 = 5;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA
    } rd_state_e;

    // Byte address of a window: each window spans 2**blk_idx beats of 32 B.
    function automatic logic [31:0] window_addr(input logic [31:0] base,
                                                input logic [31:0] idx,
                                                input int unsigned blk_idx);
        return base + (idx << (blk_idx + BEAT_BYTES_LOG2));
    endfunction

endpackage

// File: rtl/window_burst_reader_if.sv
// AXI read-address/read-data channels plus the downstream beat stream.
// master = burst reader, slave = RAM side and downstream consumer.
interface window_burst_reader_if #(
    parameter int unsigned WINDOW_WIDTH       = 256,
    parameter int unsigned WINDOW_DEPTH_INDEX = 7
) ();
    logic [3:0]                    s_axi_arid;
    logic [31:0]                   s_axi_araddr;
    logic [7:0]                    s_axi_arlen;
    logic [2:0]                    s_axi_arsize;
    logic [1:0]                    s_axi_arburst;
    logic                          s_axi_arvalid;
    logic                          s_axi_arready;
    logic [3:0]                    s_axi_rid;
    logic [WINDOW_WIDTH-1:0]       s_axi_rdata;
    logic [1:0]                    s_axi_rresp;
    logic                          s_axi_rlast;
    logic                          s_axi_rvalid;
    logic                          s_axi_rready;
    logic [WINDOW_WIDTH-1:0]       m_data;
    logic [WINDOW_DEPTH_INDEX-1:0] m_window;
    logic                          m_last;
    logic                          m_valid;
    logic                          m_ready;

    modport master (
        output s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst,
               s_axi_arvalid, s_axi_rready, m_data, m_window, m_last, m_valid,
        input  s_axi_arready, s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast,
               s_axi_rvalid, m_ready
    );

    modport slave (
        input  s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst,
               s_axi_arvalid, s_axi_rready, m_data, m_window, m_last, m_valid,
        output s_axi_arready, s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast,
               s_axi_rvalid, m_ready
    );
endinterface

// File: rtl/window_burst_reader_pending_scanner.sv
// Flag edge detection, pending-window vector and round-robin scan pointer.
// A set and a clear hitting the same window in one cycle leaves it pending.
module pending_scanner
    import threshold_cutter_pkg::*;
#(
    parameter int unsigned WINDOW_DEPTH       = 100,
    parameter int unsigned WINDOW_DEPTH_INDEX = 7
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [WINDOW_DEPTH-1:0]       i_flag,
    input  logic                          i_adv,
    input  logic                          i_load,
    input  logic [WINDOW_DEPTH_INDEX-1:0] i_load_idx,
    input  logic                          i_clr,
    input  logic [WINDOW_DEPTH_INDEX-1:0] i_clr_idx,
    output logic                          o_hit,
    output logic [WINDOW_DEPTH_INDEX-1:0] o_hit_idx
);
    logic [WINDOW_DEPTH-1:0]       r_flag_q;
    logic [WINDOW_DEPTH-1:0]       r_pending;
    logic [WINDOW_DEPTH_INDEX-1:0] r_scan_ptr;
    logic [WINDOW_DEPTH-1:0]       w_rise;
    logic [WINDOW_DEPTH-1:0]       w_clr_mask;
    logic [WINDOW_DEPTH_INDEX-1:0] w_ptr_next;

    assign w_rise     = i_flag & ~r_flag_q;
    assign w_ptr_next = (r_scan_ptr == WINDOW_DEPTH_INDEX'(WINDOW_DEPTH - 1)) ?
                        '0 : r_scan_ptr + WINDOW_DEPTH_INDEX'(1);

    always_comb begin
        w_clr_mask = '0;
        if (i_clr) begin
            w_clr_mask[i_clr_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_flag_q   <= '0;
            r_pending  <= '0;
            r_scan_ptr <= '0;
        end else begin
            r_flag_q  <= i_flag;
            r_pending <= (r_pending & ~w_clr_mask) | w_rise;
            if (i_load) begin
                r_scan_ptr <= i_load_idx;
            end else if (i_adv) begin
                r_scan_ptr <= w_ptr_next;
            end
        end
    end

    assign o_hit     = r_pending[r_scan_ptr];
    assign o_hit_idx = r_scan_ptr;
endmodule

// File: rtl/window_burst_reader.sv
// AXI4 read initiator: one INCR burst per pending window, beats streamed
// downstream unbuffered with the window index attached.
module window_burst_reader
    import threshold_cutter_pkg::*;
#(
    parameter int unsigned WINDOW_DEPTH       = 100,
    parameter int unsigned WINDOW_DEPTH_INDEX = 7,
    parameter int unsigned WINDOW_WIDTH       = 256,
    parameter int unsigned BLOCK_NUM_INDEX    = 4,
    parameter logic [31:0] BASE_ADDR          = 32'h0000_0000,
    parameter logic [3:0]  AXI_ID             = 4'h0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [WINDOW_DEPTH-1:0] ThresholdCutterWindow_flag_i,
    input  logic                    rstb_busy,
    window_burst_reader_if.master   bus,
    output logic                    err_o,
    output logic [15:0]             windows_read_o
);
    localparam logic [BLOCK_NUM_INDEX-1:0] LAST_BEAT = '1;
    localparam logic [7:0] ARLEN = 8'((1 << BLOCK_NUM_INDEX) - 1);

    rd_state_e                     r_state;
    logic [WINDOW_DEPTH_INDEX-1:0] r_cur_win;
    logic [BLOCK_NUM_INDEX-1:0]    r_beat;
    logic [31:0]                   r_araddr;
    logic                          r_arvalid;
    logic                          r_err;
    logic [15:0]                   r_cnt;

    logic                          w_hit;
    logic [WINDOW_DEPTH_INDEX-1:0] w_hit_idx;
    logic                          w_idle, w_take, w_in_data;
    logic                          w_ar_hs, w_r_hs, w_done, w_beat_err;
    logic [WINDOW_DEPTH_INDEX-1:0] w_next_win;

    assign w_idle     = (r_state == IDLE);
    assign w_in_data  = (r_state == DATA);
    assign w_take     = w_idle & w_hit & ~rstb_busy;
    assign w_ar_hs    = r_arvalid & bus.s_axi_arready;
    assign w_r_hs     = w_in_data & bus.s_axi_rvalid & bus.m_ready;
    assign w_done     = w_r_hs & bus.s_axi_rlast;
    assign w_next_win = (r_cur_win == WINDOW_DEPTH_INDEX'(WINDOW_DEPTH - 1)) ?
                        '0 : r_cur_win + WINDOW_DEPTH_INDEX'(1);

    // Beat-count mismatch covers both an early rlast and a missing one.
    assign w_beat_err = w_r_hs & ((bus.s_axi_rresp != RESP_OKAY) |
                                  (bus.s_axi_rid != AXI_ID) |
                                  (bus.s_axi_rlast != (r_beat == LAST_BEAT)));

    pending_scanner #(
        .WINDOW_DEPTH      (WINDOW_DEPTH),
        .WINDOW_DEPTH_INDEX(WINDOW_DEPTH_INDEX)
    ) u_scanner (
        .clk       (clk),
        .rst       (rst),
        .i_flag    (ThresholdCutterWindow_flag_i),
        .i_adv     (w_idle & ~w_take),
        .i_load    (w_done),
        .i_load_idx(w_next_win),
        .i_clr     (w_ar_hs),
        .i_clr_idx (r_cur_win),
        .o_hit     (w_hit),
        .o_hit_idx (w_hit_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cur_win <= '0;
            r_beat    <= '0;
            r_araddr  <= '0;
            r_arvalid <= 1'b0;
            r_err     <= 1'b0;
            r_cnt     <= '0;
        end else begin
            if (w_beat_err) begin
                r_err <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (w_take) begin
                        r_cur_win <= w_hit_idx;
                        r_araddr  <= window_addr(BASE_ADDR, 32'(w_hit_idx), BLOCK_NUM_INDEX);
                        r_arvalid <= 1'b1;
                        r_state   <= ADDR;
                    end
                end
                ADDR: begin
                    if (w_ar_hs) begin
                        r_arvalid <= 1'b0;
                        r_beat    <= '0;
                        r_state   <= DATA;
                    end
                end
                DATA: begin
                    if (w_r_hs) begin
                        r_beat <= r_beat + BLOCK_NUM_INDEX'(1);
                    end
                    if (w_done) begin
                        r_cnt   <= r_cnt + 16'd1;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.s_axi_arid    = AXI_ID;
    assign bus.s_axi_arlen   = ARLEN;
    assign bus.s_axi_arsize  = SIZE_32B;
    assign bus.s_axi_arburst = BURST_INCR;
    assign bus.s_axi_araddr  = r_araddr;
    assign bus.s_axi_arvalid = r_arvalid;

    assign bus.s_axi_rready = w_in_data & bus.m_ready;
    assign bus.m_valid      = w_in_data & bus.s_axi_rvalid;
    assign bus.m_data       = w_in_data ? bus.s_axi_rdata : '0;
    assign bus.m_window     = r_cur_win;
    assign bus.m_last       = w_in_data & bus.s_axi_rlast;

    assign err_o          = r_err;
    assign windows_read_o = r_cnt;
endmodule

// File: tb/tb_window_burst_reader.sv
// Directed bench for window_burst_reader: RAM-side responder, cycle model
// of the pending/scan/burst rules, and literal checks on key scenarios.
module tb_window_burst_reader;
    localparam int WD  = 100;
    localparam int WDI = 7;
    localparam int WW  = 256;
    localparam int BNI = 4;
    localparam int NB  = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [WD-1:0] flags = '0;
    logic          busy = 1'b0;
    logic          err;
    logic [15:0]   wcnt;

    int checks = 0;
    int errors = 0;

    window_burst_reader_if #(.WINDOW_WIDTH(WW), .WINDOW_DEPTH_INDEX(WDI)) bus ();

    window_burst_reader #(
        .WINDOW_DEPTH(WD), .WINDOW_DEPTH_INDEX(WDI), .WINDOW_WIDTH(WW),
        .BLOCK_NUM_INDEX(BNI), .BASE_ADDR(32'h0000_0000), .AXI_ID(4'h0)
    ) dut (
        .clk(clk), .rst(rst), .ThresholdCutterWindow_flag_i(flags),
        .rstb_busy(busy), .bus(bus), .err_o(err), .windows_read_o(wcnt)
    );

    always #5 clk = ~clk;

    function automatic logic [WW-1:0] pat(input int win, input int beat);
        logic [31:0] w;
        w = {8'hC0, 8'(win), 8'(beat), 8'h5A};
        return {8{w}};
    endfunction

    task automatic chk(input string nm, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Responder knobs
    int last_at   = NB - 1;
    int resp_beat = -1;

    // Observations
    int ar_order[$];
    int beats_seen = 0;
    int last_cnt   = 0;

    // Reference model state (values valid for the current cycle)
    logic [WD-1:0] m_pend = '0;
    logic [WD-1:0] m_fq   = '0;
    logic [WD-1:0] m_rise;
    int  m_ptr = 0, m_ph = 0, m_cur = 0, m_beat = 0, m_cnt = 0;
    bit  m_err = 1'b0;

    // RAM-side read responder
    initial begin
        bit s_rst, s_ar, s_r, s_l, s_act;
        int s_win, s_beat;
        logic [31:0] s_addr;
        s_act = 1'b0; s_win = 0; s_beat = 0;
        bus.s_axi_rvalid = 1'b0; bus.s_axi_rlast = 1'b0; bus.s_axi_rdata = '0;
        bus.s_axi_rresp = 2'b00; bus.s_axi_rid = 4'h0;
        forever begin
            @(negedge clk);
            s_rst  = rst;
            s_ar   = bus.s_axi_arvalid && bus.s_axi_arready;
            s_addr = bus.s_axi_araddr;
            s_r    = bus.s_axi_rvalid && bus.s_axi_rready;
            s_l    = bus.s_axi_rlast;
            @(posedge clk);
            #2;
            if (s_rst) begin
                s_act = 1'b0;
            end else begin
                if (s_r) begin
                    if (s_l) s_act = 1'b0;
                    else s_beat++;
                end
                if (s_ar) begin
                    s_act  = 1'b1;
                    s_win  = int'(s_addr >> 9);
                    s_beat = 0;
                end
            end
            bus.s_axi_rvalid = s_act;
            bus.s_axi_rdata  = s_act ? pat(s_win, s_beat) : '0;
            bus.s_axi_rlast  = s_act && (s_beat == last_at);
            bus.s_axi_rresp  = (s_act && s_beat == resp_beat) ? 2'b10 : 2'b00;
            bus.s_axi_rid    = 4'h0;
        end
    end

    // Compare against the model, then step the model with this cycle's inputs
    always @(negedge clk) begin
        chk("arvalid", bus.s_axi_arvalid, m_ph == 1);
        if (m_ph == 1) chk("araddr", bus.s_axi_araddr, m_cur * 512);
        chk("rready", bus.s_axi_rready, (m_ph == 2) && bus.m_ready);
        chk("m_valid", bus.m_valid, (m_ph == 2) && bus.s_axi_rvalid);
        if (m_ph == 2 && bus.s_axi_rvalid) begin
            chk("m_data", bus.m_data, pat(m_cur, m_beat));
            chk("m_window", bus.m_window, m_cur);
            chk("m_last", bus.m_last, bus.s_axi_rlast);
        end
        chk("err_o", err, m_err);
        chk("windows_read", wcnt, m_cnt);

        if (bus.s_axi_arvalid && bus.s_axi_arready) ar_order.push_back(int'(bus.s_axi_araddr >> 9));
        if (bus.m_valid && bus.s_axi_rready) begin
            beats_seen++;
            if (bus.m_last) begin
                last_cnt   = beats_seen;
                beats_seen = 0;
            end
        end

        if (rst) begin
            m_pend = '0; m_fq = '0; m_ptr = 0; m_ph = 0; m_cur = 0;
            m_beat = 0; m_cnt = 0; m_err = 1'b0;
            beats_seen = 0;
        end else begin
            m_rise = flags & ~m_fq;
            if (m_ph == 0) begin
                if (m_pend[m_ptr] && !busy) begin
                    m_cur = m_ptr;
                    m_ph  = 1;
                end else begin
                    m_ptr = (m_ptr + 1) % WD;
                end
            end else if (m_ph == 1) begin
                if (bus.s_axi_arready) begin
                    m_pend[m_cur] = 1'b0;
                    m_beat = 0;
                    m_ph   = 2;
                end
            end else if (bus.s_axi_rvalid && bus.m_ready) begin
                if (bus.s_axi_rresp != 2'b00 || bus.s_axi_rid != 4'h0) m_err = 1'b1;
                if (bus.s_axi_rlast && m_beat != NB - 1) m_err = 1'b1;
                if (!bus.s_axi_rlast && m_beat == NB - 1) m_err = 1'b1;
                if (bus.s_axi_rlast) begin
                    m_cnt = (m_cnt + 1) % 65536;
                    m_ptr = (m_cur + 1) % WD;
                    m_ph  = 0;
                end else begin
                    m_beat = (m_beat + 1) % NB;
                end
            end
            m_pend = m_pend | m_rise;
            m_fq   = flags;
        end
    end

    task automatic wait_done(input int target, input int budget);
        int k = 0;
        while (int'(wcnt) != target && k < budget) begin
            tick();
            k++;
        end
        chk("done_count", wcnt, target);
    endtask

    task automatic pulse(input int w);
        flags[w] = 1'b1;
        tick();
        flags[w] = 1'b0;
    endtask

    initial begin
        int k, seen, n;
        bus.s_axi_arready = 1'b1;
        bus.m_ready = 1'b1;
        repeat (3) tick();

        chk("rst_arvalid", bus.s_axi_arvalid, 1'b0);
        chk("rst_rready", bus.s_axi_rready, 1'b0);
        chk("rst_m_valid", bus.m_valid, 1'b0);
        chk("rst_m_window", bus.m_window, 0);
        chk("rst_arlen", bus.s_axi_arlen, 8'd15);
        chk("rst_arsize", bus.s_axi_arsize, 3'd5);
        chk("rst_arburst", bus.s_axi_arburst, 2'b01);
        chk("rst_arid", bus.s_axi_arid, 4'h0);
        chk("rst_err", err, 1'b0);
        chk("rst_cnt", wcnt, 16'd0);
        rst = 1'b0;
        tick();

        // Single window 3
        pulse(3);
        wait_done(1, 300);
        chk("w3_order", (ar_order.size() > 0) ? ar_order[ar_order.size()-1] : -1, 3);
        chk("w3_beats", last_cnt, 16);
        chk("w3_err", err, 1'b0);

        // Round robin: 99 and 0 together with the pointer at the top end
        k = 0;
        while (!(m_ph == 0 && m_ptr == 97) && k < 300) begin tick(); k++; end
        chk("rr_ptr_reached", k < 300, 1'b1);
        flags[99] = 1'b1; flags[0] = 1'b1;
        tick();
        flags = '0;
        wait_done(3, 400);
        n = ar_order.size();
        chk("rr_first", (n >= 2) ? ar_order[n-2] : -1, 99);
        chk("rr_second", (n >= 2) ? ar_order[n-1] : -1, 0);

        // Backpressure: m_ready toggling every cycle
        pulse(10);
        k = 0;
        while (int'(wcnt) != 4 && k < 400) begin
            bus.m_ready = ~bus.m_ready;
            tick();
            k++;
        end
        bus.m_ready = 1'b1;
        chk("bp_done", wcnt, 16'd4);
        chk("bp_beats", last_cnt, 16);

        // rstb_busy held for 50 cycles with window 5 pending
        busy = 1'b1;
        pulse(5);
        seen = 0;
        repeat (50) begin
            tick();
            if (bus.s_axi_arvalid) seen++;
        end
        busy = 1'b0;
        chk("busy_no_ar", seen, 0);
        n = ar_order.size();
        k = 0;
        while (ar_order.size() == n && k < 110) begin tick(); k++; end
        chk("busy_ar_after", (ar_order.size() > n) ? ar_order[n] : -1, 5);
        wait_done(5, 300);

        // Re-fire of window 7 during its own AR handshake
        bus.s_axi_arready = 1'b0;
        pulse(7);
        k = 0;
        while (!bus.s_axi_arvalid && k < 150) begin tick(); k++; end
        repeat (3) tick();
        chk("ar_held", bus.s_axi_arvalid, 1'b1);
        flags[7] = 1'b1;
        bus.s_axi_arready = 1'b1;
        tick();
        flags[7] = 1'b0;
        wait_done(7, 400);
        n = ar_order.size();
        chk("refire_a", (n >= 2) ? ar_order[n-2] : -1, 7);
        chk("refire_b", (n >= 2) ? ar_order[n-1] : -1, 7);

        // Error response on beat 4 is sticky
        resp_beat = 3;
        pulse(20);
        wait_done(8, 300);
        resp_beat = -1;
        chk("rresp_err", err, 1'b1);
        pulse(21);
        wait_done(9, 300);
        chk("rresp_sticky", err, 1'b1);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("clr_err", err, 1'b0);
        chk("clr_cnt", wcnt, 16'd0);

        // Early rlast on beat 8
        last_at = 7;
        pulse(30);
        wait_done(1, 300);
        last_at = NB - 1;
        chk("early_err", err, 1'b1);
        chk("early_beats", last_cnt, 8);
        pulse(31);
        wait_done(2, 300);
        chk("early_next", ar_order[ar_order.size()-1], 31);

        // Reset in the middle of a burst
        pulse(40);
        k = 0;
        while (beats_seen < 5 && k < 300) begin tick(); k++; end
        chk("mid_beats", beats_seen >= 5, 1'b1);
        rst = 1'b1;
        tick();
        chk("mid_arvalid", bus.s_axi_arvalid, 1'b0);
        chk("mid_rready", bus.s_axi_rready, 1'b0);
        chk("mid_m_valid", bus.m_valid, 1'b0);
        chk("mid_cnt", wcnt, 16'd0);
        chk("mid_err", err, 1'b0);
        rst = 1'b0;
        seen = 0;
        repeat (120) begin
            tick();
            if (bus.s_axi_arvalid) seen++;
        end
        chk("mid_no_pending", seen, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
